// File: rtl/pc_sequencer_pkg.sv
// Shared types and widths for the program-counter sequencer.
//   ADDR_W  : PC / imem address width
//   INSTR_W : instruction word width
//   CMP_W   : ALU compare result width
//   OP_W    : pc_op field width
package pc_sequencer_pkg;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned CMP_W   = 8;
   localparam int unsigned OP_W    = 2;

   // Next-PC operation supplied by the core with exec_done
   typedef enum logic [OP_W-1:0] {
      PC_OP_JMP = 2'd0,
      PC_OP_JNZ = 2'd1,
      PC_OP_JZ  = 2'd2,
      PC_OP_NOP = 2'd3
   } pc_op_e;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_e;

   // Sequential PC increment; wraps modulo 2^ADDR_W
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
      return p + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory and core handshake bundle for the sequencer.
//   imem_req/imem_addr   : fetch request and address (sequencer -> imem)
//   imem_ack/imem_data   : fetch completion and word (imem -> sequencer)
//   instr/instr_valid    : current instruction (sequencer -> core)
//   exec_done, pc_op, jmp_target, cmp_res : execute completion (core -> sequencer)
// master = sequencer side, slave = imem/core side.
interface pc_sequencer_if;
   import pc_sequencer_pkg::*;

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               exec_done;
   logic [OP_W-1:0]    pc_op;
   logic [ADDR_W-1:0]  jmp_target;
   logic [CMP_W-1:0]   cmp_res;

   modport master (
      output imem_req, imem_addr, instr, instr_valid,
      input  imem_ack, imem_data, exec_done, pc_op, jmp_target, cmp_res
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid,
      output imem_ack, imem_data, exec_done, pc_op, jmp_target, cmp_res
   );

endinterface

// File: rtl/pc_sequencer_jump_select.sv
// Jump condition decode: out == 0 means the jump is taken.
//   cmp_res : ALU compare result, unsigned
//   pc_op   : 0 always, 1 if cmp_res!=0, 2 if cmp_res==0, 3 never
//   out     : 0 = take jump, 1 = fall through
module pc_sequencer_jump_select
   import pc_sequencer_pkg::*;
(
   input  logic [CMP_W-1:0] cmp_res,
   input  logic [OP_W-1:0]  pc_op,
   output logic             out
);

   logic cmp_zero;
   assign cmp_zero = (cmp_res == CMP_W'(0));

   always_comb begin
      out = 1'b1;
      case (pc_op_e'(pc_op))
         PC_OP_JMP: out = 1'b0;
         PC_OP_JNZ: out = cmp_zero;
         PC_OP_JZ:  out = !cmp_zero;
         PC_OP_NOP: out = 1'b1;
         default:   out = 1'b1;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch from imem, present the instruction to the core,
// wait for execute completion, then load pc+1 or the jump target.
//   clk, rst_n  : clock, asynchronous active-low reset
//   run         : 1 = keep sequencing, 0 = stop at the next instruction boundary
//   bus         : imem / core handshake (master side)
//   pc          : current program counter
//   jump_taken  : one-cycle pulse after PC was loaded from jmp_target
//   idle        : high while the sequencer is stopped
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   pc_sequencer_if.master    bus,
   output logic [ADDR_W-1:0] pc,
   output logic              jump_taken,
   output logic              idle
);

   state_e state;
   logic   sel_out;
   logic   take_c;

   pc_sequencer_jump_select jump_select (
      .cmp_res (bus.cmp_res),
      .pc_op   (bus.pc_op),
      .out     (sel_out)
   );

   assign take_c        = (sel_out == 1'b0);
   // The PC register is the fetch address; it only changes outside FETCH, so it is stable
   // for the whole request.
   assign bus.imem_addr = pc;

   // Sequencer FSM with registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         pc              <= RESET_PC;
         bus.instr       <= '0;
         bus.imem_req    <= 1'b0;
         bus.instr_valid <= 1'b0;
         jump_taken      <= 1'b0;
         idle            <= 1'b1;
      end else begin
         jump_taken <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run) begin
                  state        <= S_FETCH;
                  bus.imem_req <= 1'b1;
                  idle         <= 1'b0;
               end
            end
            S_FETCH: begin
               if (bus.imem_ack) begin
                  state           <= S_EXEC;
                  bus.instr       <= bus.imem_data;
                  bus.imem_req    <= 1'b0;
                  bus.instr_valid <= 1'b1;
               end
            end
            S_EXEC: begin
               if (bus.exec_done) begin
                  pc              <= take_c ? bus.jmp_target : pc_inc(pc);
                  jump_taken      <= take_c;
                  bus.instr_valid <= 1'b0;
                  // run is sampled only at the instruction boundary
                  if (run) begin
                     state        <= S_FETCH;
                     bus.imem_req <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                     idle  <= 1'b1;
                  end
               end
            end
            default: begin
               state           <= S_IDLE;
               bus.imem_req    <= 1'b0;
               bus.instr_valid <= 1'b0;
               idle            <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of instructions with expected next PC,
// expected fetch addresses kept in a scoreboard queue, plus hand-written corner sequences.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              run   = 1'b0;
   logic [ADDR_W-1:0] pc;
   logic              jump_taken;
   logic              idle;

   pc_sequencer_if bus ();

   pc_sequencer #(.RESET_PC(8'h00)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .bus        (bus),
      .pc         (pc),
      .jump_taken (jump_taken),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] op;
      logic [7:0] cmp;
      logic [7:0] tgt;
      int         ack_dly;
      bit         spur;
      bit         simul;
      bit         rate;
      logic [7:0] exp_pc;
      bit         exp_jmp;
   } vec_t;

   vec_t       vecs [15];
   logic [7:0] exp_q [$];
   int         pass_cnt   = 0;
   int         chk_cnt    = 0;
   int         last_fetch = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.imem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("fetch_timeout", 32'(0), 32'(1));
   endtask

   // One full fetch/execute; called on a negedge, returns on the negedge after exec_done.
   task automatic run_instr(input vec_t v, input logic [15:0] data, input bit drop_run);
      bit         ok;
      logic [7:0] ea;
      wait_req(ok);
      if (!ok) return;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'(0), 32'(1));
         return;
      end
      ea = exp_q.pop_front();
      check("imem_addr", 32'(bus.imem_addr), 32'(ea));
      if (v.rate) check("cycles_per_instr", 32'(cyc - last_fetch), 32'(2));
      last_fetch = cyc;
      for (int d = 0; d < v.ack_dly; d++) begin
         if (v.spur) begin
            bus.exec_done  = 1'b1;
            bus.pc_op      = 2'd0;
            bus.jmp_target = 8'hAA;
         end
         @(negedge clk);
         check("req_held", 32'(bus.imem_req), 32'(1));
         check("addr_held", 32'(bus.imem_addr), 32'(ea));
      end
      bus.exec_done = 1'b0;
      bus.imem_ack  = 1'b1;
      bus.imem_data = data;
      @(negedge clk);
      bus.imem_ack  = 1'b0;
      bus.imem_data = '0;
      check("instr_valid", 32'(bus.instr_valid), 32'(1));
      check("instr", 32'(bus.instr), 32'(data));
      check("jump_pulse_end", 32'(jump_taken), 32'(0));
      bus.exec_done  = 1'b1;
      bus.pc_op      = v.op;
      bus.cmp_res    = v.cmp;
      bus.jmp_target = v.tgt;
      if (v.simul) begin
         bus.imem_ack  = 1'b1;
         bus.imem_data = ~data;
      end
      if (drop_run) run = 1'b0;
      exp_q.push_back(v.exp_pc);
      @(negedge clk);
      bus.exec_done = 1'b0;
      bus.imem_ack  = 1'b0;
      check("jump_taken", 32'(jump_taken), 32'(v.exp_jmp));
      check("pc", 32'(pc), 32'(v.exp_pc));
      check("instr_valid_clr", 32'(bus.instr_valid), 32'(0));
      if (v.simul) check("instr_kept", 32'(bus.instr), 32'(data));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   32'(bus.imem_req),    32'(0));
      check({tag, "_valid"}, 32'(bus.instr_valid), 32'(0));
      check({tag, "_idle"},  32'(idle),            32'(1));
      check({tag, "_pc"},    32'(pc),              32'(0));
      check({tag, "_instr"}, 32'(bus.instr),       32'(0));
      check({tag, "_jump"},  32'(jump_taken),      32'(0));
   endtask

   initial begin
      vec_t       v;
      bit         ok;
      logic [7:0] ea;

      //            op     cmp    tgt    dly spur simul rate exp_pc jmp
      vecs[0]  = '{2'd3, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0};
      vecs[1]  = '{2'd3, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0};
      vecs[2]  = '{2'd3, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0};
      vecs[3]  = '{2'd3, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0};
      vecs[4]  = '{2'd3, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0};
      vecs[5]  = '{2'd0, 8'h00, 8'h40, 0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b1};
      vecs[6]  = '{2'd1, 8'h00, 8'h90, 0, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
      vecs[7]  = '{2'd1, 8'h80, 8'h90, 0, 1'b0, 1'b0, 1'b0, 8'h90, 1'b1};
      vecs[8]  = '{2'd2, 8'h00, 8'h20, 0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1};
      vecs[9]  = '{2'd2, 8'h03, 8'h70, 0, 1'b0, 1'b0, 1'b0, 8'h21, 1'b0};
      vecs[10] = '{2'd0, 8'h00, 8'hFF, 0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1};
      vecs[11] = '{2'd3, 8'h00, 8'h12, 3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[12] = '{2'd0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[13] = '{2'd1, 8'h01, 8'h33, 0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1};
      vecs[14] = '{2'd3, 8'h05, 8'h99, 0, 1'b0, 1'b0, 1'b0, 8'h34, 1'b0};

      bus.imem_ack   = 1'b0;
      bus.imem_data  = '0;
      bus.exec_done  = 1'b0;
      bus.pc_op      = 2'd3;
      bus.jmp_target = '0;
      bus.cmp_res    = '0;

      // Reset held with run=1
      run = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      exp_q.push_back(8'h00);

      // Table-driven instruction stream
      for (int i = 0; i < 15; i++) run_instr(vecs[i], 16'hA000 + 16'(i), 1'b0);

      // run dropped in EXEC: PC update completes, then stop in IDLE
      v = '{2'd3, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h35, 1'b0};
      run_instr(v, 16'hB001, 1'b1);
      check("stop_idle", 32'(idle), 32'(1));
      check("stop_req", 32'(bus.imem_req), 32'(0));
      repeat (2) @(negedge clk);
      check("stopped_idle", 32'(idle), 32'(1));
      check("stopped_req", 32'(bus.imem_req), 32'(0));
      check("stopped_pc", 32'(pc), 32'(8'h35));
      run = 1'b1;
      v = '{2'd3, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h36, 1'b0};
      run_instr(v, 16'hB002, 1'b0);

      // Reset mid-FETCH
      wait_req(ok);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_fetch");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(8'h00);
      v = '{2'd1, 8'h05, 8'h77, 0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1};
      run_instr(v, 16'hC001, 1'b0);

      // Reset mid-EXEC
      wait_req(ok);
      ea = exp_q.pop_front();
      check("pre_rst_addr", 32'(bus.imem_addr), 32'(ea));
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'hC002;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      check("pre_rst_valid", 32'(bus.instr_valid), 32'(1));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_exec");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(8'h00);
      v = '{2'd3, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0};
      run_instr(v, 16'hC003, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
